idu_issue_ctrl: RTL

- Scoreboard-based issue controller between the decode stage's decode_valid/decode_ready handshake and the execute stage.
- Tracks destination registers of issued loads whose writeback is still outstanding, and stalls decode on RAW/WAW hazards against them.
- Serialises CSR instructions behind all outstanding loads.
- Caps the number of in-flight loads to the LSU depth.

---
 rtl/idu_issue_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/idu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : idu_issue_ctrl
// Purpose  : Scoreboard issue controller; stalls decode on load RAW/WAW
//            hazards, serialises CSR ops and caps in-flight loads.
// Revision : 1.0 - initial release
// ============================================================================
module idu_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             wr_rd,
    input  logic             is_load,
    input  logic             csr_op,
    output logic             iss_valid,
    input  logic             iss_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_map,
    output logic [2:0]       outstanding,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             sb_err
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [2:0]       c_max_out = 3'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_busy;
    logic [31:0]       w_busy_next;
    logic [2:0]        r_out;
    logic [2:0]        w_out_next;
    logic [CNT_W-1:0]  r_stall;
    logic              r_err;

    logic w_raw;
    logic w_waw;
    logic w_full;
    logic w_ser;
    logic w_go;
    logic w_ld_issue;
    logic w_wb_dec;
    logic w_wb_err;

    // Hazards look only at the registered scoreboard: no writeback bypass
    always_comb begin
        w_raw  = (use_rs1 && (rs1 != 5'd0) && r_busy[rs1]) ||
                 (use_rs2 && (rs2 != 5'd0) && r_busy[rs2]);
        w_waw  = wr_rd && (rd != 5'd0) && r_busy[rd];
        w_full = is_load && (r_out == c_max_out);
        w_ser  = csr_op && (r_out != 3'd0);
        w_go   = !w_raw && !w_waw && !w_full && !w_ser && !flush;
    end

    always_comb begin
        w_state_next = r_state;
        iss_valid    = 1'b0;
        dec_ready    = 1'b0;
        case (r_state)
            ST_RUN: begin
                iss_valid = dec_valid && w_go;
                dec_ready = iss_ready && w_go;
                if (dec_valid && csr_op && (r_out != 3'd0) && !flush)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush || (w_out_next == 3'd0))
                    w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
        if (!rst_n) begin
            iss_valid = 1'b0;
            dec_ready = 1'b0;
        end
    end

    always_comb begin
        w_ld_issue = dec_valid && dec_ready && is_load;
        // A stray writeback with nothing in flight must not underflow
        w_wb_dec   = wb_valid && (r_out != 3'd0);
        w_wb_err   = wb_valid && ((r_out == 3'd0) ||
                                  ((wb_rd != 5'd0) && !r_busy[wb_rd]));
        w_out_next = r_out + {2'b00, w_ld_issue} - {2'b00, w_wb_dec};

        w_busy_next = r_busy;
        if (wb_valid)
            w_busy_next[wb_rd] = 1'b0;
        if (w_ld_issue && (rd != 5'd0))
            w_busy_next[rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_busy  <= '0;
            r_out   <= '0;
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_out   <= w_out_next;
            if (w_wb_err)
                r_err <= 1'b1;
            if (dec_valid && !dec_ready && !flush && (r_stall != c_cnt_max))
                r_stall <= r_stall + c_cnt_one;
        end
    end

    assign busy_map     = r_busy;
    assign outstanding  = r_out;
    assign stall_cycles = r_stall;
    assign sb_err       = r_err;

endmodule
`default_nettype wire
